// File: rtl/incr_result_fifo_if.sv
// Handshake bundle between the incrementer producer, the result FIFO and
// its consumer. The slave modport is the FIFO side; the master modport is
// the combined producer/consumer environment that drives the FIFO.
interface incr_result_fifo_if #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int OVF_CNT_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // producer side
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_out;
    logic                 in_overflow;

    // consumer side
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_overflow;

    // status
    logic [CNT_W-1:0]     count;
    logic [OVF_CNT_W-1:0] ovf_count;

    modport slave (
        input  in_valid,
        input  in_out,
        input  in_overflow,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_overflow,
        output count,
        output ovf_count
    );

    modport master (
        output in_valid,
        output in_out,
        output in_overflow,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_overflow,
        input  count,
        input  ovf_count
    );
endinterface

// File: rtl/incr_result_fifo.sv
// incr_result_fifo: in-order buffer for incrementer results {overflow, out}.
// Holds up to DEPTH entries behind a valid/ready handshake on both sides and
// keeps a saturating count of accepted results that carried an overflow.
// There is no fall-through: a push into an empty FIFO shows at the head on
// the following cycle.
// Optional build macro INCR_FIFO_FULL_PASS_EN: when defined, a full FIFO
// accepts a new entry in the same cycle the consumer pops, at the cost of a
// combinational out_ready -> in_ready path. When undefined, in_ready depends
// on registered state only.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module incr_result_fifo #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    incr_result_fifo_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // each entry stores {overflow, sum}
    logic [WIDTH:0]          mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count_q;
    logic [OVF_CNT_W-1:0]    ovf_q;

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    ovf_sat;
    logic [WIDTH:0]          head;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign ovf_sat = (ovf_q == {OVF_CNT_W{1'b1}});

`ifdef INCR_FIFO_FULL_PASS_EN
    // a pop frees a slot in the same cycle, so a full FIFO can still accept
    assign bus.in_ready = !full || bus.out_ready;
`else
    // registered-only ready: a full FIFO waits one cycle after a pop
    assign bus.in_ready = !full;
`endif

    assign bus.out_valid = !empty;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.count     = count_q;
    assign bus.ovf_count = ovf_q;

    // head entry is masked to zero when empty so stale storage never leaks out
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr];
        end
        bus.out_data     = head[WIDTH-1:0];
        bus.out_overflow = head[WIDTH];
    end

    // storage write; contents need no reset because empty masks the head
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_overflow, bus.in_out};
        end
    end

    // write pointer advances on every accepted push, wrapping at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
        end
    end

    // read pointer advances on every accepted pop, wrapping at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // occupancy: push alone grows, pop alone shrinks, both together hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // overflow events seen on accepted pushes, sticking at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else if (push && bus.in_overflow && !ovf_sat) begin
            ovf_q <= ovf_q + OVF_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_incr_result_fifo.sv
// Testbench for incr_result_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the buffer.
module tb_incr_result_fifo;
    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int OVF_W   = 2;
    localparam int OVF_MAX = (1 << OVF_W) - 1;
`ifdef INCR_FIFO_FULL_PASS_EN
    localparam bit PASS = 1'b1;
`else
    localparam bit PASS = 1'b0;
`endif

    logic clk;
    logic rst_n;

    incr_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVF_CNT_W(OVF_W)) bus ();

    incr_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVF_CNT_W(OVF_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors;
    int miscompares;

    // reference model: ordered queue of {overflow, data} and overflow tally
    logic [WIDTH:0] mq[$];
    int             mocnt;

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one cycle of inputs, let the edge happen, then update the model
    task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d, input logic o, input logic r);
        bit do_push;
        bit do_pop;
        bus.in_valid    = v;
        bus.in_out      = d;
        bus.in_overflow = o;
        bus.out_ready   = r;
        do_pop  = r && (mq.size() != 0);
        do_push = v && ((mq.size() != DEPTH) || (PASS && r));
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back({o, d});
            if (o && mocnt < OVF_MAX) mocnt++;
        end
    endtask

    // reset pulse placed between clock edges; leaves inputs idle
    task automatic do_reset();
        bus.in_valid    = 1'b0;
        bus.in_out      = '0;
        bus.in_overflow = 1'b0;
        bus.out_ready   = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mq.delete();
        mocnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_out      = '0;
        bus.in_overflow = 1'b0;
        bus.out_ready   = 1'b0;
        mq.delete();
        mocnt = 0;
        #3;
        vectors++; if (bus.count !== 0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        vectors++; if (bus.out_data !== 0 || bus.out_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %0d/%b expected 0/0", bus.out_data, bus.out_overflow); end
        vectors++; if (bus.ovf_count !== 0) begin miscompares++; $display("[TB] FAIL reset_ovf_count: got %0d expected 0", bus.ovf_count); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_flow();
        logic [WIDTH-1:0] vals [4];
        logic             ovfs [4];
        vals = '{4'd1, 4'd8, 4'd15, 4'd0};
        ovfs = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, vals[i], ovfs[i], 1'b0);
            vectors++; if (bus.count !== i + 1) begin miscompares++; $display("[TB] FAIL basic_count_%0d: got %0d expected %0d", i, bus.count, i + 1); end
        end
        bus.in_valid = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_full_ready: got %b expected 0", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            bus.out_ready = 1'b1;
            #1;
            vectors++; if (bus.out_data !== vals[i] || bus.out_overflow !== ovfs[i]) begin miscompares++; $display("[TB] FAIL basic_drain_%0d: got %0d/%b expected %0d/%b", i, bus.out_data, bus.out_overflow, vals[i], ovfs[i]); end
            drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_empty: got %b expected 0", bus.out_valid); end
        vectors++; if (bus.ovf_count !== 1) begin miscompares++; $display("[TB] FAIL basic_ovf_count: got %0d expected 1", bus.ovf_count); end
    endtask

    task automatic test_first_word();
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_out   = 4'd4;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL first_word_same_cycle: got %b expected 0", bus.out_valid); end
        drive_cycle(1'b1, 4'd4, 1'b0, 1'b0);
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd4) begin miscompares++; $display("[TB] FAIL first_word_next_cycle: got %b/%0d expected 1/4", bus.out_valid, bus.out_data); end
        drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_full_rejection();
        logic [WIDTH-1:0] exp_drain [4];
        int               n_drain;
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 4'(10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 4'd7, 1'b0, 1'b0);
            vectors++; if (bus.count !== DEPTH || bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_hold_%0d: got count %0d ready %b expected 4/0", i, bus.count, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== PASS) begin miscompares++; $display("[TB] FAIL full_pop_ready: got %b expected %b", bus.in_ready, PASS); end
        drive_cycle(1'b1, 4'd7, 1'b0, 1'b1);
        vectors++; if (bus.count !== (PASS ? 4 : 3)) begin miscompares++; $display("[TB] FAIL full_pop_count: got %0d expected %0d", bus.count, PASS ? 4 : 3); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_after_pop_ready: got %b expected 1", bus.in_ready); end
        exp_drain = '{4'd11, 4'd12, 4'd13, 4'd7};
        n_drain = PASS ? 4 : 3;
        bus.in_valid = 1'b0;
        for (int i = 0; i < n_drain; i++) begin
            #1;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_drain[i]) begin miscompares++; $display("[TB] FAIL full_drain_%0d: got %b/%0d expected 1/%0d", i, bus.out_valid, bus.out_data, exp_drain[i]); end
            drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL full_drain_empty: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_head;
        do_reset();
        drive_cycle(1'b1, 4'd10, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd11, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_head = (i == 0) ? 4'd10 : (i == 1) ? 4'd11 : 4'(i - 2);
            vectors++; if (bus.out_data !== exp_head) begin miscompares++; $display("[TB] FAIL b2b_head_%0d: got %0d expected %0d", i, bus.out_data, exp_head); end
            drive_cycle(1'b1, 4'(i), 1'b0, 1'b1);
            vectors++; if (bus.count !== 2) begin miscompares++; $display("[TB] FAIL b2b_count_%0d: got %0d expected 2", i, bus.count); end
        end
        for (int i = 8; i < 10; i++) begin
            vectors++; if (bus.out_data !== 4'(i)) begin miscompares++; $display("[TB] FAIL b2b_tail_%0d: got %0d expected %0d", i, bus.out_data, i); end
            drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_saturation();
        int exp_sat [5];
        exp_sat = '{1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 4'(i), 1'b1, (i != 0));
            vectors++; if (bus.ovf_count !== exp_sat[i]) begin miscompares++; $display("[TB] FAIL sat_%0d: got %0d expected %0d", i, bus.ovf_count, exp_sat[i]); end
        end
        drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        vectors++; if (bus.ovf_count !== 3) begin miscompares++; $display("[TB] FAIL sat_after_pop: got %0d expected 3", bus.ovf_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cycle(1'b1, 4'd5, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'd6, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd9, 1'b1, 1'b0);
        vectors++; if (bus.count !== 3 || bus.ovf_count !== 2) begin miscompares++; $display("[TB] FAIL mid_pre: got %0d/%0d expected 3/2", bus.count, bus.ovf_count); end
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.count !== 0 || bus.ovf_count !== 0) begin miscompares++; $display("[TB] FAIL mid_async_counts: got %0d/%0d expected 0/0", bus.count, bus.ovf_count); end
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_data !== 0) begin miscompares++; $display("[TB] FAIL mid_async_out: got %b/%0d expected 0/0", bus.out_valid, bus.out_data); end
        rst_n = 1'b1;
        mq.delete();
        mocnt = 0;
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 4'd3, 1'b0, 1'b0);
        vectors++; if (bus.count !== 1 || bus.out_data !== 4'd3 || bus.out_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_repush: got %0d/%0d/%b expected 1/3/0", bus.count, bus.out_data, bus.out_overflow); end
        drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_alone: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_random();
        logic             v, o, r;
        logic [WIDTH-1:0] d;
        logic [WIDTH:0]   exp_head;
        logic             exp_ready;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            d = 4'($urandom);
            o = ($urandom_range(0, 7) == 0);
            drive_cycle(v, d, o, r);
            exp_head  = (mq.size() != 0) ? mq[0] : '0;
            exp_ready = (mq.size() != DEPTH) || (PASS && r);
            vectors++; if (bus.count !== mq.size()) begin miscompares++; $display("[TB] FAIL rand_count_%0d: got %0d expected %0d", i, bus.count, mq.size()); end
            vectors++; if (bus.out_valid !== (mq.size() != 0)) begin miscompares++; $display("[TB] FAIL rand_valid_%0d: got %b expected %b", i, bus.out_valid, mq.size() != 0); end
            vectors++; if ({bus.out_overflow, bus.out_data} !== exp_head) begin miscompares++; $display("[TB] FAIL rand_head_%0d: got %h expected %h", i, {bus.out_overflow, bus.out_data}, exp_head); end
            vectors++; if (bus.in_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL rand_ready_%0d: got %b expected %b", i, bus.in_ready, exp_ready); end
            vectors++; if (bus.ovf_count !== mocnt) begin miscompares++; $display("[TB] FAIL rand_ovf_%0d: got %0d expected %0d", i, bus.ovf_count, mocnt); end
        end
    endtask

    // run the scenarios in order and report
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic_flow();
        test_first_word();
        test_full_rejection();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
